// File: rtl/sc_memio_pkg.sv
// sc_memio_pkg: shared constants and helpers for the sc_memio_bus data-memory / MMIO block.
// I/O word offsets, CTRL bit positions, the timer bit inside MASK, and the byte-lane merge.
package sc_memio_pkg;

    // I/O word offsets, counted from the start of I/O space.
    localparam int OFF_OUT   = 0;
    localparam int OFF_IN    = 8;
    localparam int OFF_CHG   = 16;
    localparam int OFF_MASK  = 17;
    localparam int OFF_LOAD  = 18;
    localparam int OFF_COUNT = 19;
    localparam int OFF_CTRL  = 20;

    // Bit positions inside CTRL.
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_EXP  = 2;

    // MASK bit that gates the timer-expired flag onto irq.
    localparam int MASK_TIMER_BIT = 8;

    // Take each byte from new_word where its enable is set, otherwise keep old_word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/sc_memio_timer.sv
// sc_memio_timer: down-counting timer with reload value, EN/AUTO control and a sticky EXP flag.
// Only built when SC_MEMIO_TIMER_EN is defined.
// Priorities: a LOAD write beats decrement/reload, a CTRL.EN write beats the
// hardware EN clear, and a hardware EXP set beats a same-cycle write-1-to-clear.
module sc_memio_timer
    import sc_memio_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        wr_load,
    input  logic        wr_ctrl,
    input  logic [31:0] wdata,
    output logic [31:0] load,
    output logic [31:0] count,
    output logic [2:0]  ctrl
);

    logic [31:0] load_q, load_n;
    logic [31:0] count_q, count_n;
    logic [2:0]  ctrl_q, ctrl_n;
    logic        expire;

    // Next-state: hardware count step first, then CPU writes layered on top by priority.
    always_comb begin
        load_n  = load_q;
        count_n = count_q;
        ctrl_n  = ctrl_q;
        expire  = 1'b0;
        if (ctrl_q[CTRL_EN] && count_q != 32'd0) begin
            count_n = count_q - 32'd1;
            if (count_q == 32'd1) begin
                expire = 1'b1;
                if (ctrl_q[CTRL_AUTO])
                    count_n = load_q;
                else
                    ctrl_n[CTRL_EN] = 1'b0;
            end
        end
        if (wr_ctrl) begin
            ctrl_n[CTRL_EN]   = wdata[CTRL_EN];
            ctrl_n[CTRL_AUTO] = wdata[CTRL_AUTO];
            if (wdata[CTRL_EXP])
                ctrl_n[CTRL_EXP] = 1'b0;
        end
        if (expire)
            ctrl_n[CTRL_EXP] = 1'b1;
        if (wr_load) begin
            load_n  = wdata;
            count_n = wdata;
        end
    end

    // Timer state registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            load_q  <= '0;
            count_q <= '0;
            ctrl_q  <= '0;
        end else begin
            load_q  <= load_n;
            count_q <= count_n;
            ctrl_q  <= ctrl_n;
        end
    end

    assign load  = load_q;
    assign count = count_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/sc_memio_bus.sv
// sc_memio_bus: single-cycle CPU data RAM plus memory-mapped I/O (output ports,
// synchronised inputs with sticky change flags, optional timer, one irq line).
// addr[IO_BIT] selects I/O (1) or RAM (0). RAM reads are combinational.
// Define SC_MEMIO_TIMER_EN to build the timer (LOAD/COUNT/CTRL and MASK bit 8).
module sc_memio_bus
    import sc_memio_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int IO_BIT = 7,
    parameter int N_OUT  = 3,
    parameter int N_IN   = 2,
    parameter int IN_W   = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [31:0]            addr,
    input  logic [31:0]            datain,
    input  logic                   we,
    input  logic [3:0]             be,
    output logic [31:0]            dataout,
    input  logic [N_IN*IN_W-1:0]   in_port,
    output logic [N_OUT*32-1:0]    out_port,
    output logic                   irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = IO_BIT - 2;

    logic          is_io;
    logic [OW-1:0] off;
    logic [31:0]   off32;
    logic [AW-1:0] widx;
    logic          io_we, ram_we;
    logic          wr_chg, wr_mask;

    assign is_io  = addr[IO_BIT];
    assign off    = addr[IO_BIT-1:2];
    assign off32  = 32'(off);
    assign widx   = addr[AW+1:2];
    assign io_we  = we &  is_io;
    assign ram_we = we & ~is_io;
    assign wr_chg  = io_we && (off32 == 32'(OFF_CHG));
    assign wr_mask = io_we && (off32 == 32'(OFF_MASK));

    // Address bits above the I/O select and the byte offset carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^{addr[31:IO_BIT+1], addr[1:0]};

    // ---------------- RAM ----------------
    logic [31:0] mem [DEPTH];

    // Byte-lane RAM write; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (ram_we)
            mem[widx] <= byte_merge(mem[widx], datain, be);
    end

    // ---------------- output ports ----------------
    logic [N_OUT-1:0][31:0] out_q;

    // Output port registers with byte-enable writes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_q <= '0;
        end else if (io_we) begin
            for (int k = 0; k < N_OUT; k++)
                if (off32 == 32'(OFF_OUT + k))
                    out_q[k] <= byte_merge(out_q[k], datain, be);
        end
    end

    assign out_port = out_q;

    // ---------------- inputs and change detect ----------------
    logic [N_IN-1:0][IN_W-1:0] sync1, sync2, prev;
    logic [N_IN-1:0]           chg_q, chg_n, chg_hit;
    logic [N_IN-1:0]           mask_in;
    logic                      mask_tmr;
    logic                      tmr_exp;

    // Two-flop synchroniser plus previous-value register for edge detection.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Sticky change flags: W1C from the CPU, then hardware set wins.
    always_comb begin
        chg_hit = '0;
        for (int k = 0; k < N_IN; k++)
            chg_hit[k] = (sync2[k] != prev[k]);
        chg_n = chg_q;
        if (wr_chg)
            chg_n = chg_n & ~datain[N_IN-1:0];
        chg_n = chg_n | chg_hit;
    end

    // CHG, MASK and registered irq.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            chg_q   <= '0;
            mask_in <= '0;
            irq     <= 1'b0;
        end else begin
            chg_q <= chg_n;
            if (wr_mask)
                mask_in <= datain[N_IN-1:0];
            irq <= (|(chg_q & mask_in)) | (tmr_exp & mask_tmr);
        end
    end

    // ---------------- timer ----------------
`ifdef SC_MEMIO_TIMER_EN
    logic [31:0] tmr_load, tmr_count;
    logic [2:0]  tmr_ctrl;

    sc_memio_timer u_timer (
        .clock   (clock),
        .resetn  (resetn),
        .wr_load (io_we && (off32 == 32'(OFF_LOAD))),
        .wr_ctrl (io_we && (off32 == 32'(OFF_CTRL))),
        .wdata   (datain),
        .load    (tmr_load),
        .count   (tmr_count),
        .ctrl    (tmr_ctrl)
    );

    assign tmr_exp = tmr_ctrl[CTRL_EXP];

    // Timer gate bit of MASK.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            mask_tmr <= 1'b0;
        else if (wr_mask)
            mask_tmr <= datain[MASK_TIMER_BIT];
    end
`else
    assign tmr_exp  = 1'b0;
    assign mask_tmr = 1'b0;
`endif

    // ---------------- load mux ----------------
    // Combinational load data; unmapped I/O offsets return zero.
    always_comb begin
        dataout = '0;
        if (!is_io) begin
            dataout = mem[widx];
        end else begin
            for (int k = 0; k < N_OUT; k++)
                if (off32 == 32'(OFF_OUT + k))
                    dataout = out_q[k];
            for (int k = 0; k < N_IN; k++)
                if (off32 == 32'(OFF_IN + k))
                    dataout[IN_W-1:0] = sync2[k];
            if (off32 == 32'(OFF_CHG))
                dataout[N_IN-1:0] = chg_q;
            if (off32 == 32'(OFF_MASK)) begin
                dataout[N_IN-1:0]         = mask_in;
                dataout[MASK_TIMER_BIT]   = mask_tmr;
            end
`ifdef SC_MEMIO_TIMER_EN
            if (off32 == 32'(OFF_LOAD))
                dataout = tmr_load;
            if (off32 == 32'(OFF_COUNT))
                dataout = tmr_count;
            if (off32 == 32'(OFF_CTRL))
                dataout[2:0] = tmr_ctrl;
`endif
        end
    end

endmodule

// File: doc/sc_memio_bus.md
Name: sc_memio_bus

Overview:
- Next-generation data-memory plus memory-mapped I/O block for the single-cycle CPU.
- Adds parametrised RAM depth and port counts, byte-enable writes, synchronised inputs with sticky change detection, a down-counting timer and one interrupt line.
- Runs on one clock, with no separate memory clock.
- Sits between the CPU load/store datapath and the board I/O pins.

Parameters:
- DEPTH, 32, RAM size in 32-bit words; power of two, 2..2^(IO_BIT-2).
- IO_BIT, 7, address bit that selects I/O space (1) or RAM (0).
- N_OUT, 3, number of 32-bit output ports, 1..8.
- N_IN, 2, number of input ports, 1..8.
- IN_W, 4, width of each input port, 1..32.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- addr  in  32  byte address; bits [1:0] are ignored.
- datain  in  32  store data.
- we  in  1  store strobe.
- be  in  4  byte enables; be[i] covers datain[8i+7:8i].
- dataout  out  32  load data, combinational from addr.
- in_port  in  N_IN*IN_W  asynchronous board inputs; port k at [k*IN_W +: IN_W].
- out_port  out  N_OUT*32  output port registers; port k at [k*32 +: 32].
- irq  out  1  level interrupt request.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `resetn` is asynchronous and active-low.
- Reset values:
  - out_port = 0, irq = 0.
  - Input synchronisers and previous-value registers = 0.
  - CHG = 0, MASK = 0, LOAD = 0, COUNT = 0, CTRL = 0.
  - RAM contents are not reset.
- Space select: addr[IO_BIT] = 0 selects RAM; 1 selects I/O. Writes to the unselected space never occur.
- RAM access:
  - Word index is addr[log2(DEPTH)+1:2]; higher bits below IO_BIT alias.
  - Read is combinational, zero wait states.
  - Write occurs on the rising edge when we = 1, merging only the bytes with be set. be = 0 is a no-op.
- I/O word offset is off = addr[IO_BIT-1:2].
- I/O register map:
  - off 0..N_OUT-1 — OUTk: R/W; byte-enable writes; read returns the register.
  - off 8..8+N_IN-1 — INk: read-only; returns the synchronised input, zero-extended.
  - off 16 — CHG: bit k sticky. Set when the synchronised INk differs from its previous-cycle value. Write-1-to-clear.
  - off 17 — MASK: bits [N_IN-1:0] gate CHG; bit 8 gates the timer flag.
  - off 18 — LOAD: a write sets LOAD and also COUNT to datain.
  - off 19 — COUNT: read-only.
  - off 20 — CTRL: bit0 EN, bit1 AUTO, bit2 EXP (EXP is write-1-to-clear). Bits 0 and 1 are written directly.
- Register rules:
  - Writes to offsets 16..20 ignore be.
  - Unmapped offsets read 0 and ignore writes.
  - Loads have no side effects.
- Input path: two-flop synchroniser per port. An input edge is visible in INk 2 cycles later and sets CHG 3 cycles later.
- Timer, each cycle:
  - If EN = 1 and COUNT ≠ 0, COUNT decrements.
  - On the 1→0 step, EXP sets. If AUTO = 1, COUNT reloads LOAD on that same edge; otherwise EN clears.
  - EN = 1 with COUNT = 0 holds and does not set EXP.
  - LOAD = 0 with AUTO = 1 expires once, then holds at 0.
- Simultaneous events:
  - A hardware set of a CHG or EXP bit wins over a same-cycle write-1-to-clear.
  - A CPU write to LOAD wins over a decrement or reload.
  - A CPU write to CTRL.EN wins over a hardware EN clear.
- irq is registered: irq <= |(CHG & MASK[N_IN-1:0]) | (EXP & MASK[8]). It has 1 cycle of latency after the cause.
- Reset asserted mid-operation clears all I/O state immediately. A RAM write in flight is undefined.

Optional Feature:
- Macro: SC_MEMIO_TIMER_EN.
- Defined: the timer registers at offsets 18..20 exist and MASK bit 8 is live.
- Undefined:
  - No timer logic is built.
  - Offsets 18..20 read 0 and ignore writes.
  - EXP is treated as constant 0 in irq.

Decomposition:
- Package sc_memio_pkg holds:
  - the I/O offset constants (OFF_OUT = 0, OFF_IN = 8, OFF_CHG = 16, OFF_MASK = 17, OFF_LOAD = 18, OFF_COUNT = 19, OFF_CTRL = 20);
  - the CTRL bit positions;
  - MASK_TIMER_BIT = 8;
  - a byte-merge function (old, new, be).
- One natural sub-module, sc_memio_timer: holds LOAD, COUNT and CTRL and produces EXP.

Test Plan:
- Byte-lane RAM write: write 0x11223344 to RAM addr 0x04 with be = 4'b1111, then write 0xAABBCCDD with be = 4'b0101 → a load returns 0x11BB33DD. A write to 0x84 leaves RAM word 1 unchanged.
- Output port: write 0xDEADBEEF to off 1 (addr 0x84) → out_port[63:32] = 0xDEADBEEF on the next edge. Reading addr 0x84 returns the same value.
- Input change and interrupt:
  - Set MASK = 0x1, then drive in_port[3:0] from 0 to 0x5 → INk reads 0x5 after 2 cycles, CHG = 0x1 after 3, irq = 1 after 4.
  - Write CHG = 0x1 → irq = 0.
- Timer one-shot: LOAD = 3, CTRL = 0x1, MASK = 0x100 → COUNT reads 2, 1, 0 on successive cycles; EXP = 1 and EN = 0 at COUNT 0; irq follows 1 cycle later.
- Timer auto-reload with collision: LOAD = 2, CTRL = 0x3 → EXP pulses every 2 cycles. A write-1-to-clear of EXP on the expiring cycle leaves EXP = 1.
- Asynchronous reset mid-count: drop resetn during the count → out_port, COUNT, CTRL, CHG and irq are 0 immediately, without waiting for a clock edge.
